pc_redirect_controller: RTL and testbench
=========================================

Name: pc_redirect_controller

Overview:
Sequential program-counter controller for the RV64 core. It issues sequential instruction-fetch requests and applies redirects from resolved branches (EX stage) and JAL (ID stage). On each redirect it flushes the younger pipeline stages for a fixed number of cycles. It sits between the branch/jump resolution logic and the instruction memory port, and owns the architectural fetch PC.

Parameters:
XLEN, 64, PC and address width
RESET_PC, 64'h0, PC loaded on reset
FLUSH_CYCLES, 2, cycles flush_o stays high after a redirect (legal range 1..7)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  reset; asynchronous assert, active-low
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  imem accepts request this cycle
imem_addr  output  XLEN  fetch address; always equals pc_o
stall_i  input  1  hazard stall from decode; holds the PC
br_valid  input  1  EX-stage conditional branch resolved this cycle
br_taken  input  1  branch outcome; qualified by br_valid
br_pc  input  XLEN  PC of the resolving branch
br_offset  input  21  signed byte offset of the branch
jal_valid  input  1  ID-stage JAL decoded this cycle
jal_pc  input  XLEN  PC of the JAL
jal_offset  input  21  signed byte offset of the JAL
pc_o  output  XLEN  current fetch PC
flush_o  output  1  kill the IF/ID contents
fault_o  output  1  sticky misaligned-target fault
redirect_cnt  output  16  saturating count of applied redirects

Behaviour:
- Reset (rst_n low, any time, including mid-flush): state=BOOT, pc_o=RESET_PC, imem_req_valid=0, flush_o=0, fault_o=0, redirect_cnt=0, flush counter=0.
- States: BOOT, FETCH, FLUSH, FAULT.
- BOOT: lasts exactly 1 cycle after rst_n deasserts, then moves to FETCH. No request is issued in BOOT.
- FETCH:
  - imem_req_valid = ~stall_i.
  - Request accepted (valid & ready) with no redirect: pc_o += 4 on the next edge. Otherwise pc_o holds.
- Target arithmetic:
  - target = src_pc + sign-extend(offset to XLEN), with bit 0 of the result forced to 0.
  - Sums wrap modulo 2^XLEN; there is no overflow detection.
- Redirect sources, evaluated in FETCH only:
  - br_valid & br_taken takes priority over jal_valid, because EX is older.
  - br_valid & ~br_taken is no action, and does not block a simultaneous JAL.
- Redirect with target[1]=0:
  - pc_o <= target.
  - state <= FLUSH; flush counter <= FLUSH_CYCLES.
  - redirect_cnt += 1, saturating at 16'hFFFF.
  - A fetch handshake in the same cycle is discarded and does not advance the PC.
- Redirect with target[1]=1 (misaligned):
  - state <= FAULT; fault_o <= 1; pc_o unchanged.
  - redirect_cnt is not incremented.
- A redirect overrides stall_i.
- FLUSH:
  - flush_o=1 and imem_req_valid=0.
  - The counter decrements each cycle; at 1 the next state is FETCH.
  - Flush therefore lasts exactly FLUSH_CYCLES cycles.
  - br_valid and jal_valid are ignored, since those instructions are being flushed.
- FAULT: imem_req_valid=0, flush_o=1, fault_o=1. Left only by reset.
- Latency: a redirect asserted in cycle N gives pc_o=target and flush_o=1 in cycle N+1. The first request to the target issues in cycle N+1+FLUSH_CYCLES.
- All outputs are registered except imem_req_valid, which is decoded from the state and stall_i.

Test Plan:
1. Reset, then hold imem_req_ready=1 for 4 cycles -> BOOT for 1 cycle; pc_o steps through 0, 4, 8, 12; imem_addr == pc_o throughout.
2. Taken branch: br_pc=0x100, br_offset=-16, ready=1 -> next cycle pc_o=0xF0 and flush_o=1 for 2 cycles with no requests; cycle+3 request at 0xF0; redirect_cnt=1.
3. Same cycle: br_valid&taken (target 0x200) and jal_valid (target 0x400) -> pc_o=0x200. Then repeat with br_taken=0 -> pc_o=0x400.
4. stall_i=1 for 3 cycles with ready=1 -> imem_req_valid=0 and pc_o constant. A JAL with target 0x80 arriving during the stall still redirects.
5. JAL with jal_pc=0x10, jal_offset=6 -> target 0x16 (bit1=1) -> fault_o=1, FAULT state, no requests until rst_n pulses low; after reset pc_o=RESET_PC and fault_o=0.
6. Assert rst_n low mid-FLUSH, plus a redirect during FLUSH (ignored) -> async clear of all outputs, with no stale redirect applied after reset.

Source files
------------

// File: rtl/pc_redirect_controller.sv
// Fetch PC owner: sequential fetch, branch/JAL redirects, timed flush.
// A misaligned redirect target parks the controller in FAULT until reset.
module pc_redirect_controller #(
  parameter int unsigned      XLEN         = 64,
  parameter logic [XLEN-1:0]  RESET_PC     = '0,
  parameter int unsigned      FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            stall_i,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic [20:0]     br_offset,
  input  logic            jal_valid,
  input  logic [XLEN-1:0] jal_pc,
  input  logic [20:0]     jal_offset,
  output logic [XLEN-1:0] pc_o,
  output logic            flush_o,
  output logic            fault_o,
  output logic [15:0]     redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            fault_q, fault_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      fcnt_q, fcnt_d;

  logic [XLEN-1:0] br_tgt, jal_tgt, tgt;
  logic            br_take, redir, mis;

  assign br_tgt = (br_pc + {{(XLEN-21){br_offset[20]}}, br_offset})
                  & ~{{(XLEN-1){1'b0}}, 1'b1};
  assign jal_tgt = (jal_pc + {{(XLEN-21){jal_offset[20]}}, jal_offset})
                   & ~{{(XLEN-1){1'b0}}, 1'b1};

  // EX-stage branch is older than the ID-stage JAL, so it wins.
  assign br_take = br_valid & br_taken;
  assign redir   = br_take | jal_valid;
  assign tgt     = br_take ? br_tgt : jal_tgt;
  assign mis     = tgt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        if (redir) state_d = mis ? FAULT : FLUSH;
      end
      FLUSH: begin
        if (fcnt_q <= 3'd1) state_d = FETCH;
      end
      FAULT: state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    fcnt_d = fcnt_q;
    unique case (state_q)
      FETCH: begin
        if (redir) begin
          if (!mis) begin
            pc_d   = tgt;
            fcnt_d = FC;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end
        end else if (imem_req_valid && imem_req_ready) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      FLUSH: begin
        if (fcnt_q != 3'd0) fcnt_d = fcnt_q - 3'd1;
      end
      default: ;
    endcase
    flush_d = (state_d == FLUSH) || (state_d == FAULT);
    fault_d = fault_q | (state_d == FAULT);
  end

  always_comb begin
    imem_req_valid = (state_q == FETCH) && !stall_i;
  end

  assign pc_o         = pc_q;
  assign imem_addr    = pc_q;
  assign flush_o      = flush_q;
  assign fault_o      = fault_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Directed bench for pc_redirect_controller.
// Hand-computed expected values, checked 1ns after each rising edge.
module tb_pc_redirect_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        stall_i;
  logic        br_valid;
  logic        br_taken;
  logic [63:0] br_pc;
  logic [20:0] br_offset;
  logic        jal_valid;
  logic [63:0] jal_pc;
  logic [20:0] jal_offset;
  logic [63:0] pc_o;
  logic        flush_o;
  logic        fault_o;
  logic [15:0] redirect_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_redirect_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .stall_i        (stall_i),
    .br_valid       (br_valid),
    .br_taken       (br_taken),
    .br_pc          (br_pc),
    .br_offset      (br_offset),
    .jal_valid      (jal_valid),
    .jal_pc         (jal_pc),
    .jal_offset     (jal_offset),
    .pc_o           (pc_o),
    .flush_o        (flush_o),
    .fault_o        (fault_o),
    .redirect_cnt   (redirect_cnt)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag,
                           input logic [63:0] pc,
                           input logic v, input logic fl,
                           input logic ft);
    check({tag, ".pc"}, pc_o, pc);
    check({tag, ".addr"}, imem_addr, pc);
    check({tag, ".valid"}, {63'd0, imem_req_valid}, {63'd0, v});
    check({tag, ".flush"}, {63'd0, flush_o}, {63'd0, fl});
    check({tag, ".fault"}, {63'd0, fault_o}, {63'd0, ft});
  endtask

  task automatic clr_redir();
    br_valid  = 1'b0;
    br_taken  = 1'b0;
    jal_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    stall_i        = 1'b0;
    br_valid       = 1'b0;
    br_taken       = 1'b0;
    br_pc          = '0;
    br_offset      = '0;
    jal_valid      = 1'b0;
    jal_pc         = '0;
    jal_offset     = '0;

    step();
    step();
    chk_state("rst", 64'h0, 1'b0, 1'b0, 1'b0);
    check("rst.cnt", {48'd0, redirect_cnt}, 64'd0);

    // 1: boot then sequential fetch
    imem_req_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk_state("boot", 64'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk_state("seq0", 64'h0, 1'b1, 1'b0, 1'b0);
    step();
    chk_state("seq4", 64'h4, 1'b1, 1'b0, 1'b0);
    step();
    chk_state("seq8", 64'h8, 1'b1, 1'b0, 1'b0);
    step();
    chk_state("seq12", 64'hC, 1'b1, 1'b0, 1'b0);

    // 2: taken branch backwards, handshake in same cycle discarded
    br_valid  = 1'b1;
    br_taken  = 1'b1;
    br_pc     = 64'h100;
    br_offset = 21'h1FFFF0;
    step();
    clr_redir();
    chk_state("br.f1", 64'hF0, 1'b0, 1'b1, 1'b0);
    check("br.cnt", {48'd0, redirect_cnt}, 64'd1);
    step();
    chk_state("br.f2", 64'hF0, 1'b0, 1'b1, 1'b0);
    step();
    chk_state("br.req", 64'hF0, 1'b1, 1'b0, 1'b0);
    step();
    chk_state("br.next", 64'hF4, 1'b1, 1'b0, 1'b0);

    // 3: branch beats JAL; bit 0 of 0x201 forced low
    br_valid   = 1'b1;
    br_taken   = 1'b1;
    br_pc      = 64'h100;
    br_offset  = 21'h101;
    jal_valid  = 1'b1;
    jal_pc     = 64'h300;
    jal_offset = 21'h100;
    step();
    clr_redir();
    chk_state("pri.br", 64'h200, 1'b0, 1'b1, 1'b0);
    check("pri.cnt", {48'd0, redirect_cnt}, 64'd2);
    step();
    step();
    chk_state("pri.back", 64'h200, 1'b1, 1'b0, 1'b0);
    br_valid  = 1'b1;
    br_taken  = 1'b0;
    jal_valid = 1'b1;
    step();
    clr_redir();
    chk_state("pri.jal", 64'h400, 1'b0, 1'b1, 1'b0);
    check("pri.cnt2", {48'd0, redirect_cnt}, 64'd3);
    step();
    step();

    // 4: stall holds the PC; JAL still redirects under stall
    stall_i = 1'b1;
    #1;
    chk_state("stl0", 64'h400, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state("stl", 64'h400, 1'b0, 1'b0, 1'b0);
    end
    jal_valid  = 1'b1;
    jal_pc     = 64'h40;
    jal_offset = 21'h40;
    step();
    clr_redir();
    chk_state("stl.jal", 64'h80, 1'b0, 1'b1, 1'b0);
    check("stl.cnt", {48'd0, redirect_cnt}, 64'd4);
    stall_i = 1'b0;
    step();
    step();
    chk_state("stl.back", 64'h80, 1'b1, 1'b0, 1'b0);

    // 5: misaligned JAL target 0x16 -> sticky fault
    jal_valid  = 1'b1;
    jal_pc     = 64'h10;
    jal_offset = 21'h6;
    step();
    clr_redir();
    chk_state("flt", 64'h80, 1'b0, 1'b1, 1'b1);
    check("flt.cnt", {48'd0, redirect_cnt}, 64'd4);
    br_valid  = 1'b1;
    br_taken  = 1'b1;
    br_pc     = 64'h0;
    br_offset = 21'h40;
    step();
    step();
    clr_redir();
    chk_state("flt.hold", 64'h80, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("flt.rst", 64'h0, 1'b0, 1'b0, 1'b0);
    check("flt.rstcnt", {48'd0, redirect_cnt}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk_state("flt.fetch", 64'h0, 1'b1, 1'b0, 1'b0);

    // 6: reset in the middle of a flush, with a redirect pending
    br_valid  = 1'b1;
    br_taken  = 1'b1;
    br_pc     = 64'h0;
    br_offset = 21'h40;
    step();
    clr_redir();
    chk_state("mf.f1", 64'h40, 1'b0, 1'b1, 1'b0);
    jal_valid  = 1'b1;
    jal_pc     = 64'h300;
    jal_offset = 21'h100;
    step();
    chk_state("mf.ign", 64'h40, 1'b0, 1'b1, 1'b0);
    check("mf.cnt", {48'd0, redirect_cnt}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("mf.rst", 64'h0, 1'b0, 1'b0, 1'b0);
    check("mf.rstcnt", {48'd0, redirect_cnt}, 64'd0);
    step();
    clr_redir();
    rst_n = 1'b1;
    #1;
    chk_state("mf.boot", 64'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk_state("mf.fetch", 64'h0, 1'b1, 1'b0, 1'b0);
    step();
    chk_state("mf.seq", 64'h4, 1'b1, 1'b0, 1'b0);
    check("mf.cnt0", {48'd0, redirect_cnt}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
